// File: rtl/if_stage.sv
// Instruction fetch: PC register with a direct-mapped, one-word-per-line I-cache.
// A miss is filled from memory over a level request that is answered by a one-cycle ready pulse.
module if_stage #(
  parameter int ADDR_WIDTH = 17,
  parameter int ICACHE_IDX = 7
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        stall_hold,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        mem_if_ready,
  input  logic [31:0] mem_if_data,
  output logic        if_mem_req,
  output logic [31:0] if_mem_addr,
  output logic [31:0] if_pc,
  output logic [31:0] if_ins,
  output logic        stall_req_if
);

  localparam int          LINES = 1 << ICACHE_IDX;
  localparam int          TAG_W = ADDR_WIDTH - ICACHE_IDX - 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t            state;
  logic [31:0]       pc;
  logic [31:0]       fetch_addr;
  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [31:0]       data_mem [LINES];

  logic [ICACHE_IDX-1:0] idx;
  logic [ICACHE_IDX-1:0] fill_idx;
  logic [TAG_W-1:0]      pc_tag;
  logic [TAG_W-1:0]      fill_tag;
  logic                  hit;
  logic                  fill;

  assign idx      = pc[ICACHE_IDX+1:2];
  assign pc_tag   = pc[ADDR_WIDTH-1:ICACHE_IDX+2];
  assign fill_idx = fetch_addr[ICACHE_IDX+1:2];
  assign fill_tag = fetch_addr[ADDR_WIDTH-1:ICACHE_IDX+2];

  // Lookup reads the arrays before any same-cycle fill lands, so a fill is visible next cycle.
  assign hit  = (state == S_IDLE) && valid[idx] && (tag_mem[idx] == pc_tag);
  assign fill = (state == S_WAIT) && mem_if_ready;

  assign if_mem_req   = (state == S_WAIT);
  assign if_mem_addr  = (state == S_WAIT) ? fetch_addr : 32'h0;
  assign if_pc        = hit ? pc : 32'h0;
  assign if_ins       = hit ? data_mem[idx] : NOP;
  assign stall_req_if = !hit;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state      <= S_IDLE;
      pc         <= 32'h0;
      fetch_addr <= 32'h0;
      valid      <= '0;
    end else if (rdy_in) begin
      if (branch_taken) begin
        pc <= branch_target;
      end else if (hit && !stall_hold) begin
        pc <= pc + 32'd4;
      end

      // A redirect never aborts an outstanding fill; the line is still written.
      case (state)
        S_IDLE: begin
          if (!hit) begin
            state      <= S_WAIT;
            fetch_addr <= {pc[31:2], 2'b00};
          end
        end
        S_WAIT: begin
          if (mem_if_ready) begin
            state           <= S_IDLE;
            valid[fill_idx] <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && fill) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= mem_if_data;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: expected instructions go into a queue, a monitor pops one per valid presentation.
module tb_if_stage;

  localparam int MEM_LAT = 3;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        stall_hold;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        mem_if_ready;
  logic [31:0] mem_if_data;
  logic        if_mem_req;
  logic [31:0] if_mem_addr;
  logic [31:0] if_pc;
  logic [31:0] if_ins;
  logic        stall_req_if;

  if_stage #(.ADDR_WIDTH(17), .ICACHE_IDX(7)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .stall_hold    (stall_hold),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .mem_if_ready  (mem_if_ready),
    .mem_if_data   (mem_if_data),
    .if_mem_req    (if_mem_req),
    .if_mem_addr   (if_mem_addr),
    .if_pc         (if_pc),
    .if_ins        (if_ins),
    .stall_req_if  (stall_req_if)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   mem_cnt     = 0;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a == 32'h0) ? 32'h0050_0093 : ((a << 8) | 32'h0000_0093);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [31:0] a);
    exp_t e;
    e.pc  = a;
    e.ins = memword(a);
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Counts stall cycles from now until the next presented instruction.
  task automatic wait_hit(input string name, input int exp_stalls,
                          input logic [31:0] first_addr, input logic [31:0] last_addr);
    int          n    = 0;
    logic [31:0] seen = 32'hFFFF_FFFF;
    logic [31:0] bad  = 32'h0;
    while (stall_req_if !== 1'b0 && n < 100) begin
      if (if_mem_req === 1'b1) begin
        seen = if_mem_addr;
        if (if_mem_addr !== first_addr && if_mem_addr !== last_addr) bad = 32'h1;
      end
      n++;
      step();
    end
    check({name, "_stalls"}, n, exp_stalls);
    check({name, "_last_addr"}, seen, last_addr);
    check({name, "_addr_bad"}, bad, 32'h0);
    check({name, "_req_at_hit"}, {31'h0, if_mem_req}, 32'h0);
  endtask

  task automatic check_hit_noreq(input string name);
    check({name, "_stall"}, {31'h0, stall_req_if}, 32'h0);
    check({name, "_req"}, {31'h0, if_mem_req}, 32'h0);
  endtask

  task automatic check_reset_outs(input string name);
    check({name, "_req"}, {31'h0, if_mem_req}, 32'h0);
    check({name, "_addr"}, if_mem_addr, 32'h0);
    check({name, "_pc"}, if_pc, 32'h0);
    check({name, "_ins"}, if_ins, 32'h0000_0013);
    check({name, "_stall"}, {31'h0, stall_req_if}, 32'h1);
  endtask

  // Memory controller: answers a request MEM_LAT enabled cycles after it first appears.
  initial begin
    mem_if_ready = 1'b0;
    mem_if_data  = 32'hDEAD_BEEF;
    forever begin
      @(posedge clk_in);
      #2;
      mem_if_ready = 1'b0;
      mem_if_data  = 32'hDEAD_BEEF;
      if (rst_in) begin
        mem_cnt = 0;
      end else if (rdy_in && if_mem_req === 1'b1) begin
        mem_cnt++;
        if (mem_cnt == MEM_LAT + 1) begin
          mem_if_ready = 1'b1;
          mem_if_data  = memword(if_mem_addr);
          mem_cnt      = 0;
        end
      end
    end
  end

  // Monitor: every cycle with a valid instruction consumes one expectation.
  always @(negedge clk_in) begin
    if (rst_in === 1'b0 && rdy_in === 1'b1 && stall_req_if === 1'b0) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_ins: got pc %h ins %h, expected none at %0t", if_pc, if_ins, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("mon_pc", if_pc, e.pc);
        check("mon_ins", if_ins, e.ins);
      end
    end
  end

  initial begin
    rst_in        = 1'b1;
    rdy_in        = 1'b1;
    stall_hold    = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    repeat (3) step();
    rst_in = 1'b0;
    check_reset_outs("reset");

    // Cold start: 5 stall cycles, then 0x0, 0x4, 0x8, 0xC each miss.
    push_exp(32'h0);
    wait_hit("cold0", 5, 32'h0, 32'h0);
    for (int a = 4; a <= 12; a += 4) begin
      push_exp(32'(a));
      step();
      wait_hit("seq", 5, 32'(a), 32'(a));
    end

    // Branch back to 0: second pass hits every cycle; hold at 0x8 for three cycles.
    branch_taken  = 1'b1;
    branch_target = 32'h0;
    push_exp(32'h0);
    push_exp(32'h4);
    repeat (4) push_exp(32'h8);
    push_exp(32'hC);
    step();
    branch_taken = 1'b0;
    check_hit_noreq("pass2_0");
    step();
    check_hit_noreq("pass2_4");
    step();
    check_hit_noreq("pass2_8a");
    stall_hold = 1'b1;
    repeat (2) begin
      step();
      check_hit_noreq("hold_8");
    end
    step();
    stall_hold = 1'b0;
    check_hit_noreq("hold_8_last");
    step();
    check_hit_noreq("pass2_C");

    // Redirect to 0x100 during the fill of 0x10: fill completes, then 0x100 misses.
    step();
    check("miss10_stall", {31'h0, stall_req_if}, 32'h1);
    check("miss10_req_idle", {31'h0, if_mem_req}, 32'h0);
    step();
    check("wait10_req", {31'h0, if_mem_req}, 32'h1);
    check("wait10_addr", if_mem_addr, 32'h10);
    branch_taken  = 1'b1;
    branch_target = 32'h100;
    step();
    branch_taken = 1'b0;
    check("wait10_addr_held", if_mem_addr, 32'h10);
    push_exp(32'h100);
    wait_hit("redir100", 8, 32'h10, 32'h100);

    // Jump to 0x10 hits because the aborted-looking fill did land.
    branch_taken  = 1'b1;
    branch_target = 32'h10;
    push_exp(32'h10);
    step();
    check_hit_noreq("hit10");

    // 0x200 shares index 0 with 0x0 and evicts it.
    branch_target = 32'h200;
    push_exp(32'h200);
    step();
    branch_taken = 1'b0;
    wait_hit("fill200", 5, 32'h200, 32'h200);
    branch_taken  = 1'b1;
    branch_target = 32'h0;
    push_exp(32'h0);
    step();
    branch_taken = 1'b0;
    wait_hit("evicted0", 5, 32'h0, 32'h0);

    // Chip enable low mid-WAIT: everything frozen, including a redirect.
    branch_taken  = 1'b1;
    branch_target = 32'h300;
    push_exp(32'h300);
    step();
    branch_taken = 1'b0;
    step();
    step();
    rdy_in        = 1'b0;
    branch_taken  = 1'b1;
    branch_target = 32'h40;
    for (int i = 0; i < 4; i++) begin
      check("frozen_req", {31'h0, if_mem_req}, 32'h1);
      check("frozen_addr", if_mem_addr, 32'h300);
      step();
    end
    rdy_in       = 1'b1;
    branch_taken = 1'b0;
    wait_hit("after_rdy", 3, 32'h300, 32'h300);

    // Reset in the middle of the 0x304 fill.
    step();
    step();
    step();
    check("wait304_req", {31'h0, if_mem_req}, 32'h1);
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    check_reset_outs("midwait_rst");
    push_exp(32'h0);
    wait_hit("post_rst", 5, 32'h0, 32'h0);

    step();
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
